// File: rtl/digit_entry_pkg.sv
// Shared types, defaults and the modulo step helper for the code-entry counter.
package digit_entry_pkg;

  typedef enum logic {
    ST_ENTRY,
    ST_DONE
  } state_e;

  localparam int DEF_NUM_DIGITS = 4;
  localparam int DEF_RADIX      = 10;
  localparam int DEF_DIGIT_W    = 4;

  function automatic logic [7:0] mod_step(
    input logic [7:0] d,
    input logic       up,
    input logic [7:0] radix
  );
    if (up)
      return (d == radix - 8'd1) ? 8'd0 : d + 8'd1;
    return (d == 8'd0) ? radix - 8'd1 : d - 8'd1;
  endfunction

endpackage

// File: rtl/digit_entry_counter_btn_edge_detect.sv
// Rising-edge detector for one debounced button level.
// A button held high through reset release must drop before it can fire.
module btn_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic evt
);

  logic btn_q, btn_d;
  logic arm_q, arm_d;

  always_comb begin
    btn_d = btn;
    arm_d = arm_q | ~btn;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q <= 1'b0;
      arm_q <= 1'b0;
    end else begin
      btn_q <= btn_d;
      arm_q <= arm_d;
    end
  end

  assign evt = btn & ~btn_q & arm_q;

endmodule

// File: rtl/digit_entry_counter.sv
// Multi-digit code-entry counter for the lock front panel.
// Define CODE_TIMEOUT_EN to add the inactivity clear and timeout_clr port.
module digit_entry_counter
  import digit_entry_pkg::*;
#(
  parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
  parameter int RADIX       = DEF_RADIX,
  parameter int DIGIT_W     = DEF_DIGIT_W,
  parameter int TIMEOUT_CYC = 1000,
  localparam int AW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                          clk_slow,
  input  logic                          rst,
  input  logic                          btn_inc,
  input  logic                          btn_dec,
  input  logic                          btn_confirm,
  input  logic                          btn_clear,
  output logic [NUM_DIGITS*DIGIT_W-1:0] digits,
  output logic [AW-1:0]                 active_digit,
  output logic                          entry_done,
  output logic                          code_valid
`ifdef CODE_TIMEOUT_EN
  ,
  output logic                          timeout_clr
`endif
);

  localparam logic [AW-1:0] LAST = AW'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 2 || NUM_DIGITS > 8 ||
      RADIX < 2 || RADIX > 16 ||
      DIGIT_W > 8 || (1 << DIGIT_W) < RADIX ||
      TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("digit_entry_counter: illegal parameters");
  end

  logic ev_inc, ev_dec, ev_cfm, ev_clr;

  btn_edge_detect u_inc (
    .clk(clk_slow), .rst(rst),
    .btn(btn_inc), .evt(ev_inc)
  );
  btn_edge_detect u_dec (
    .clk(clk_slow), .rst(rst),
    .btn(btn_dec), .evt(ev_dec)
  );
  btn_edge_detect u_cfm (
    .clk(clk_slow), .rst(rst),
    .btn(btn_confirm), .evt(ev_cfm)
  );
  btn_edge_detect u_clr (
    .clk(clk_slow), .rst(rst),
    .btn(btn_clear), .evt(ev_clr)
  );

  state_e                             state_q, state_d;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] dig_q, dig_d;
  logic [AW-1:0]                      act_q, act_d;
  logic                               done_q, done_d;
  logic                               tmo_hit;

`ifdef CODE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          any_ev;

  assign any_ev  = ev_inc | ev_dec | ev_cfm | ev_clr;
  assign tmo_hit = (cnt_q == TW'(TIMEOUT_CYC));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q != ST_ENTRY || tmo_hit || any_ev)
      cnt_d = '0;
    else if (act_q != '0 || dig_q != '0)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_slow or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign timeout_clr = tmo_hit;
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    act_d   = act_q;
    done_d  = 1'b0;
    if (ev_clr || tmo_hit) begin
      state_d = ST_ENTRY;
      dig_d   = '0;
      act_d   = '0;
    end else if (state_q == ST_ENTRY) begin
      // simultaneous inc and dec cancel each other
      if (ev_inc ^ ev_dec) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (act_q == AW'(i))
            dig_d[i] = DIGIT_W'(mod_step(8'(dig_q[i]),
                                         ev_inc, 8'(RADIX)));
        end
      end
      if (ev_cfm) begin
        if (act_q == LAST) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          act_d = act_q + 1'b1;
        end
      end
    end else if (ev_cfm) begin
      state_d = ST_ENTRY;
      dig_d   = '0;
      act_d   = '0;
    end
  end

  always_ff @(posedge clk_slow or posedge rst) begin
    if (rst) begin
      state_q <= ST_ENTRY;
      dig_q   <= '0;
      act_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      act_q   <= act_d;
      done_q  <= done_d;
    end
  end

  assign digits       = dig_q;
  assign active_digit = act_q;
  assign entry_done   = done_q;
  assign code_valid   = (state_q == ST_DONE);

endmodule

// File: tb/tb_digit_entry_counter.sv
// Scoreboard bench for digit_entry_counter (default and RADIX=6 instances).
// Timeout checks run when CODE_TIMEOUT_EN is defined.
module tb_digit_entry_counter;

  localparam logic [3:0] INC = 4'b0001;
  localparam logic [3:0] DEC = 4'b0010;
  localparam logic [3:0] CFM = 4'b0100;
  localparam logic [3:0] CLR = 4'b1000;

  typedef struct {
    int          sel;
    logic [15:0] d;
    logic [1:0]  a;
    logic        done;
    logic        valid;
    logic        tmo;
    string       nm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] b_a = '0;
  logic [3:0] b_6 = '0;

  logic [15:0] dig_a, dig_6;
  logic [1:0]  act_a, act_6;
  logic        done_a, done_6, val_a, val_6;
  logic        tmo_a;

  exp_t sb[$];
  exp_t e;
  int   nvec = 0;
  int   nbad = 0;

  always #5 clk = ~clk;

  digit_entry_counter #(
    .TIMEOUT_CYC(20)
  ) dut_a (
    .clk_slow(clk), .rst(rst),
    .btn_inc(b_a[0]), .btn_dec(b_a[1]),
    .btn_confirm(b_a[2]), .btn_clear(b_a[3]),
    .digits(dig_a), .active_digit(act_a),
    .entry_done(done_a), .code_valid(val_a)
`ifdef CODE_TIMEOUT_EN
    , .timeout_clr(tmo_a)
`endif
  );

`ifndef CODE_TIMEOUT_EN
  assign tmo_a = 1'b0;
`else
  logic tmo_6;
`endif

  digit_entry_counter #(
    .RADIX(6)
  ) dut_6 (
    .clk_slow(clk), .rst(rst),
    .btn_inc(b_6[0]), .btn_dec(b_6[1]),
    .btn_confirm(b_6[2]), .btn_clear(b_6[3]),
    .digits(dig_6), .active_digit(act_6),
    .entry_done(done_6), .code_valid(val_6)
`ifdef CODE_TIMEOUT_EN
    , .timeout_clr(tmo_6)
`endif
  );

  task automatic check(input exp_t x, input logic [15:0] d,
                       input logic [1:0] a, input logic dn,
                       input logic v, input logic t);
    nvec++;
    if (d !== x.d || a !== x.a || dn !== x.done ||
        v !== x.valid || t !== x.tmo) begin
      nbad++;
      $display("FAIL %s: got d=%h a=%0d done=%b valid=%b tmo=%b, want d=%h a=%0d done=%b valid=%b tmo=%b",
               x.nm, d, a, dn, v, t,
               x.d, x.a, x.done, x.valid, x.tmo);
    end
  endtask

  // monitor: one expectation per clock, sampled just after the edge
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.sel == 0)
        check(e, dig_a, act_a, done_a, val_a, tmo_a);
      else
        check(e, dig_6, act_6, done_6, val_6, 1'b0);
    end
  end

  task automatic cyc(input int sel, input logic [3:0] b,
                     input logic [15:0] d, input logic [1:0] a,
                     input logic dn, input logic v,
                     input logic t, input string nm);
    exp_t x;
    @(negedge clk);
    b_a = (sel == 0) ? b : 4'b0;
    b_6 = (sel == 0) ? 4'b0 : b;
    x = '{sel, d, a, dn, v, t, nm};
    sb.push_back(x);
    @(posedge clk);
  endtask

  task automatic press(input int sel, input logic [3:0] b,
                       input logic [15:0] d, input logic [1:0] a,
                       input logic dn, input logic v,
                       input string nm);
    cyc(sel, b, d, a, dn, v, 1'b0, nm);
    cyc(sel, 4'b0, d, a, 1'b0, v, 1'b0, nm);
  endtask

  initial begin
    logic [15:0] x;
    exp_t z;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc(0, 4'b0, 16'h0000, 0, 0, 0, 0, "reset");

    repeat (5) cyc(0, INC, 16'h0001, 0, 0, 0, 0, "inc_held");
    cyc(0, 4'b0, 16'h0001, 0, 0, 0, 0, "inc_release");
    for (int k = 1; k <= 9; k++)
      press(0, INC, 16'((1 + k) % 10), 0, 0, 0, "inc_wrap");
    press(0, DEC, 16'h0009, 0, 0, 0, "dec_wrap");
    press(0, CLR, 16'h0000, 0, 0, 0, "clear");

    press(1, DEC, 16'h0005, 0, 0, 0, "r6_dec_wrap");
    press(1, INC, 16'h0000, 0, 0, 0, "r6_inc_wrap");

    x = 16'h0000;
    for (int j = 0; j < 4; j++) begin
      for (int n = 0; n <= j; n++) begin
        x = x + (16'h0001 << (4 * j));
        press(0, INC, x, 2'(j), 0, 0, "enter_inc");
      end
      if (j < 3)
        press(0, CFM, x, 2'(j + 1), 0, 0, "enter_cfm");
    end
    press(0, CFM, 16'h4321, 3, 1, 1, "entry_done");
    press(0, INC, 16'h4321, 3, 0, 1, "done_frozen");
    press(0, CFM, 16'h0000, 0, 0, 0, "done_exit");

    press(0, CFM, 16'h0000, 1, 0, 0, "to_digit1");
    x = 16'h0000;
    for (int n = 0; n < 7; n++) begin
      x = x + 16'h0010;
      press(0, INC, x, 1, 0, 0, "digit1_inc");
    end
    press(0, INC | CFM, 16'h0080, 2, 0, 0, "inc_cfm");
    press(0, INC | DEC, 16'h0080, 2, 0, 0, "inc_dec");
    press(0, INC, 16'h0180, 2, 0, 0, "digit2_inc");
    press(0, CLR | INC | CFM, 16'h0000, 0, 0, 0, "clr_prio");

    press(0, INC, 16'h0001, 0, 0, 0, "pre_rst");
    press(0, CFM, 16'h0001, 1, 0, 0, "pre_rst");
    press(0, CFM, 16'h0001, 2, 0, 0, "pre_rst");
    press(0, CFM, 16'h0001, 3, 0, 0, "pre_rst");
    press(0, INC, 16'h1001, 3, 0, 0, "pre_rst");

    #3 rst = 1'b1;
    #1;
    z = '{0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0, "async_rst"};
    check(z, dig_a, act_a, done_a, val_a, tmo_a);
    b_a = INC;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc(0, INC, 16'h0000, 0, 0, 0, 0, "held_thru_rst");
    cyc(0, INC, 16'h0000, 0, 0, 0, 0, "held_thru_rst");
    cyc(0, 4'b0, 16'h0000, 0, 0, 0, 0, "held_release");
    press(0, INC, 16'h0001, 0, 0, 0, "repress");
    press(0, CLR, 16'h0000, 0, 0, 0, "clear2");

`ifdef CODE_TIMEOUT_EN
    press(0, INC, 16'h0001, 0, 0, 0, "tmo_setup");
    press(0, INC, 16'h0002, 0, 0, 0, "tmo_setup");
    press(0, INC, 16'h0003, 0, 0, 0, "tmo_setup");
    repeat (18) cyc(0, 4'b0, 16'h0003, 0, 0, 0, 0, "tmo_idle");
    cyc(0, 4'b0, 16'h0003, 0, 0, 0, 1, "tmo_pulse");
    cyc(0, 4'b0, 16'h0000, 0, 0, 0, 0, "tmo_cleared");

    press(0, INC, 16'h0001, 0, 0, 0, "tmo_restart");
    repeat (17) cyc(0, 4'b0, 16'h0001, 0, 0, 0, 0, "tmo_idle2");
    cyc(0, INC, 16'h0002, 0, 0, 0, 0, "tmo_inc19");
    repeat (19) cyc(0, 4'b0, 16'h0002, 0, 0, 0, 0, "tmo_no_clr");
    cyc(0, 4'b0, 16'h0002, 0, 0, 0, 1, "tmo_pulse2");
    cyc(0, 4'b0, 16'h0000, 0, 0, 0, 0, "tmo_cleared2");
`endif

    repeat (3) @(posedge clk);
    #2;
    nvec++;
    if (sb.size() != 0) begin
      nbad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/digit_entry_counter.md
Name: digit_entry_counter

Overview:
- Parametrised multi-digit code-entry counter for the electronic lock front panel.
- Takes debounced level buttons and edge-detects them internally, so a held button counts once.
- Keeps NUM_DIGITS digits, each counting modulo RADIX in both directions; the user steps through them with confirm.
- Signals a completed code to the downstream comparator and drives the 7-segment mux through a flat digit bus.

Parameters:
- NUM_DIGITS, 4: number of digits in the code; must be 2..8.
- RADIX, 10: digit modulus; must be 2..16.
- DIGIT_W, 4: bits per digit; must satisfy 2^DIGIT_W >= RADIX.
- TIMEOUT_CYC, 1000: inactivity limit in clk_slow cycles; used only with CODE_TIMEOUT_EN.

Ports:
- clk_slow  in  1  single clock (slow, post-divider).
- rst  in  1  reset; asynchronous, active-high.
- btn_inc  in  1  debounced level; increment the active digit.
- btn_dec  in  1  debounced level; decrement the active digit.
- btn_confirm  in  1  debounced level; advance to the next digit or finish entry.
- btn_clear  in  1  debounced level; abort entry and zero all digits.
- digits  out  NUM_DIGITS*DIGIT_W  digit i at bits [i*DIGIT_W +: DIGIT_W]; digit 0 is entered first.
- active_digit  out  max(1,$clog2(NUM_DIGITS))  index of the digit being edited.
- entry_done  out  1  one-cycle pulse when the last digit is confirmed.
- code_valid  out  1  high while in DONE (digits frozen).

Behaviour:
- Reset (async assert, sync release): all digits 0, active_digit 0, entry_done 0, code_valid 0, state ENTRY, edge-detect history regs 0.
- Edge detect: each button has a registered copy; event = btn & ~btn_q. A button already high when reset releases yields no event until it drops and rises again.
- Latency: outputs update on the first clk_slow rising edge at which the raised button is sampled. entry_done and code_valid are registered and assert on that same edge.
- FSM has two states.
- ENTRY:
  - inc: digit[active] = (d == RADIX-1) ? 0 : d+1.
  - dec: digit[active] = (d == 0) ? RADIX-1 : d-1.
  - confirm with active < NUM_DIGITS-1: active_digit+1.
  - confirm with active == NUM_DIGITS-1: go to DONE, pulse entry_done one cycle, code_valid=1, active_digit stays NUM_DIGITS-1.
- DONE:
  - inc and dec are ignored; digits are frozen.
  - confirm or clear: go to ENTRY, all digits 0, active_digit 0, code_valid 0.
- Priority within one cycle, highest first:
  - clear: zero all digits, active 0, state ENTRY, code_valid 0; every other event that cycle is discarded.
  - inc and dec together: cancel, no digit change.
  - inc or dec together with confirm: the inc/dec applies to the current digit, then active advances (both take effect that cycle).
- No saturation: active_digit never exceeds NUM_DIGITS-1. Digit values outside 0..RADIX-1 are unreachable.
- Reset asserted mid-entry or in DONE returns immediately to reset values; an entry_done pulse in flight is squashed.

Optional Feature:
- Macro: CODE_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYC+1) reloads to 0 on any button event.
  - It increments each cycle while in ENTRY with (active_digit != 0 or any digit != 0).
  - On reaching TIMEOUT_CYC it performs a clear-equivalent action (all digits 0, active_digit 0) and pulses output timeout_clr (1 bit, present only under the macro) for one cycle.
  - The counter is held at 0 in DONE and in reset.
- Undefined: no counter, no timeout_clr port; entry persists indefinitely.

Decomposition:
- Package digit_entry_pkg holds:
  - state enum {ST_ENTRY, ST_DONE};
  - default constants for NUM_DIGITS/RADIX/DIGIT_W;
  - a function for the modulo inc/dec step.
- One sub-module, btn_edge_detect: 1-bit rising-edge detector with async active-high reset, instantiated once per button (4 instances).
- Digit storage, FSM and timeout stay in the top module.

Test Plan:
- Defaults, reset, then inc held high for 5 cycles -> digit0=1 only (one event per press); release, 9 more presses -> digit0 wraps to 0.
- dec on digit0=0 -> digit0=9. With RADIX=6 override, dec from 0 -> 5 and inc from 5 -> 0.
- Enter 1-2-3-4 with confirms -> entry_done pulses exactly one cycle, code_valid=1, digits=16'h4321. Then inc -> digits unchanged. Then confirm -> all 0, active 0, code_valid 0.
- Same-cycle rising edges:
  - inc+confirm on digit1=7 -> digit1=8, active=2.
  - inc+dec -> no change.
  - clear+inc+confirm at active=2 -> all 0, active 0.
- Assert rst asynchronously between clock edges at active=3 with digits nonzero -> outputs 0 immediately; btn_inc held through reset release -> no count until re-pressed.
- With CODE_TIMEOUT_EN and TIMEOUT_CYC=20, enter digit0=3 then idle 20 cycles -> timeout_clr pulse, digits 0. Pressing inc at cycle 19 restarts the count with no clear.
